// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - 2-way L1 data cache miss controller; optional perf counters under DCACHE_PERF_CNT_EN
module dcache_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [31:0] addr,
    output logic        ready,
    output logic        stall,
    output logic        hit,
    output logic [7:0]  index,
    output logic        block0_rw,
    output logic        block1_rw,
    output logic        dirty_wd,
    output logic [20:0] tag_wd,
    input  logic [20:0] tag0_rd,
    input  logic [20:0] tag1_rd,
    input  logic        dirty0,
    input  logic        dirty1,
    input  logic        lru,
    input  logic        complete,
    output logic        l2_req,
    output logic        l2_rw,
    output logic [27:0] l2_addr,
    input  logic        l2_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam logic WRITE = 1'b1;
    localparam logic READ  = 1'b0;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_COMPARE    = 3'd1;
    localparam logic [2:0] S_WRITE_BACK = 3'd2;
    localparam logic [2:0] S_REFILL     = 3'd3;
    localparam logic [2:0] S_UPDATE     = 3'd4;
    localparam logic [2:0] S_WAIT_CMPL  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [19:0] ltag_q;
    logic [7:0]  lindex_q;
    logic        lrw_q;
    logic        vway_q;
    logic [19:0] vtag_q;

    // The byte offset never matters to the controller: whole lines move.
    logic [3:0]  unused_offset;
    assign unused_offset = addr[3:0];

    logic hit0, hit1, any_hit;
    logic victim_valid, victim_dirty;
    logic [19:0] victim_tag;

    assign hit0    = tag0_rd[20] & (tag0_rd[19:0] == ltag_q);
    assign hit1    = tag1_rd[20] & (tag1_rd[19:0] == ltag_q);
    assign any_hit = hit0 | hit1;

    // Victim selection follows the LRU bit read for this set.
    assign victim_valid = lru ? tag1_rd[20]    : tag0_rd[20];
    assign victim_dirty = lru ? dirty1         : dirty0;
    assign victim_tag   = lru ? tag1_rd[19:0]  : tag0_rd[19:0];

    // Next-state and all controller outputs are decoded from the current state.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        stall     = (state_q != S_IDLE);
        hit       = 1'b0;
        index     = (state_q == S_IDLE) ? addr[11:4] : lindex_q;
        block0_rw = READ;
        block1_rw = READ;
        dirty_wd  = 1'b0;
        tag_wd    = 21'd0;
        l2_req    = 1'b0;
        l2_rw     = READ;
        l2_addr   = 28'd0;
        case (state_q)
            S_IDLE: begin
                if (req) state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if (any_hit) begin
                    // Rewriting the hit way refreshes LRU; way 0 wins a double match.
                    hit    = 1'b1;
                    tag_wd = {1'b1, ltag_q};
                    if (hit0) begin
                        block0_rw = WRITE;
                        dirty_wd  = (lrw_q == WRITE) | dirty0;
                    end else begin
                        block1_rw = WRITE;
                        dirty_wd  = (lrw_q == WRITE) | dirty1;
                    end
                    state_d = S_WAIT_CMPL;
                end else if (victim_valid & victim_dirty) begin
                    state_d = S_WRITE_BACK;
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_WRITE_BACK: begin
                l2_req  = 1'b1;
                l2_rw   = WRITE;
                l2_addr = {vtag_q, lindex_q};
                if (l2_ack) state_d = S_REFILL;
            end
            S_REFILL: begin
                l2_req  = 1'b1;
                l2_rw   = READ;
                l2_addr = {ltag_q, lindex_q};
                if (l2_ack) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                tag_wd   = {1'b1, ltag_q};
                dirty_wd = (lrw_q == WRITE);
                if (vway_q) block1_rw = WRITE;
                else        block0_rw = WRITE;
                state_d = S_WAIT_CMPL;
            end
            S_WAIT_CMPL: begin
                if (complete) begin
                    ready   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Latch the request on accept and the victim identity on a miss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ltag_q   <= 20'd0;
            lindex_q <= 8'd0;
            lrw_q    <= READ;
            vway_q   <= 1'b0;
            vtag_q   <= 20'd0;
        end else begin
            if (state_q == S_IDLE && req) begin
                ltag_q   <= addr[31:12];
                lindex_q <= addr[11:4];
                lrw_q    <= rw;
            end
            if (state_q == S_COMPARE && !any_hit) begin
                vway_q <= lru;
                vtag_q <= victim_tag;
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Count every tag comparison outcome; counters wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (state_q == S_COMPARE) begin
            if (any_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else         miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl with a behavioural tag RAM
module tb_dcache_ctrl;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        rw = RD;
    logic [31:0] addr = 32'd0;
    logic        ready, stall, hit;
    logic [7:0]  index;
    logic        block0_rw, block1_rw, dirty_wd;
    logic [20:0] tag_wd;
    logic [20:0] tag0_rd = 21'd0, tag1_rd = 21'd0;
    logic        dirty0 = 1'b0, dirty1 = 1'b0, lru = 1'b0, complete = 1'b0;
    logic        l2_req, l2_rw;
    logic [27:0] l2_addr;
    logic        l2_ack = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;

    int checks = 0;
    int failures = 0;

    dcache_ctrl dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .addr(addr),
        .ready(ready), .stall(stall), .hit(hit), .index(index),
        .block0_rw(block0_rw), .block1_rw(block1_rw), .dirty_wd(dirty_wd), .tag_wd(tag_wd),
        .tag0_rd(tag0_rd), .tag1_rd(tag1_rd), .dirty0(dirty0), .dirty1(dirty1),
        .lru(lru), .complete(complete),
        .l2_req(l2_req), .l2_rw(l2_rw), .l2_addr(l2_addr), .l2_ack(l2_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Tag RAM model: registered read, write on strobe, complete one cycle later.
    logic [20:0] tmem0 [256];
    logic [20:0] tmem1 [256];
    logic        dmem0 [256];
    logic        dmem1 [256];
    logic        lmem  [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            tmem0[i] = 21'd0; tmem1[i] = 21'd0;
            dmem0[i] = 1'b0;  dmem1[i] = 1'b0; lmem[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        tag0_rd  <= tmem0[index];
        tag1_rd  <= tmem1[index];
        dirty0   <= dmem0[index];
        dirty1   <= dmem1[index];
        lru      <= lmem[index];
        complete <= (block0_rw == WR) || (block1_rw == WR);
        if (block0_rw == WR) begin
            tmem0[index] <= tag_wd; dmem0[index] <= dirty_wd; lmem[index] <= 1'b1;
        end
        if (block1_rw == WR) begin
            tmem1[index] <= tag_wd; dmem1[index] <= dirty_wd; lmem[index] <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Present a request in IDLE; returns sampled in the COMPARE cycle.
    task automatic issue(input logic r, input logic [31:0] a);
        req = 1'b1; rw = r; addr = a;
        #1;
        check("idle_index", {56'd0, index}, {56'd0, a[11:4]});
        cyc();
        check("cmp_stall", {63'd0, stall}, 64'd1);
        check("cmp_index", {56'd0, index}, {56'd0, a[11:4]});
    endtask

    task automatic hit_phase(input logic way, input logic dw, input logic [20:0] twd);
        check("hit_flag", {63'd0, hit}, 64'd1);
        check("hit_b0", {63'd0, block0_rw}, {63'd0, (way == 1'b0) ? WR : RD});
        check("hit_b1", {63'd0, block1_rw}, {63'd0, (way == 1'b1) ? WR : RD});
        check("hit_dirty_wd", {63'd0, dirty_wd}, {63'd0, dw});
        check("hit_tag_wd", {43'd0, tag_wd}, {43'd0, twd});
        check("hit_l2_req", {63'd0, l2_req}, 64'd0);
        cyc();
        check("hit_ready", {63'd0, ready}, 64'd1);
        check("hit_l2_req2", {63'd0, l2_req}, 64'd0);
        req = 1'b0;
        cyc();
        check("hit_idle_ready", {63'd0, ready}, 64'd0);
        check("hit_idle_stall", {63'd0, stall}, 64'd0);
    endtask

    task automatic miss_cmp();
        check("miss_flag", {63'd0, hit}, 64'd0);
        check("miss_b0", {63'd0, block0_rw}, {63'd0, RD});
        check("miss_b1", {63'd0, block1_rw}, {63'd0, RD});
        check("miss_l2_req", {63'd0, l2_req}, 64'd0);
        cyc();
    endtask

    // One L2 transaction, acked after 'delay' extra cycles of stable request.
    task automatic l2_phase(input string nm, input logic erw, input logic [27:0] ea, input int delay);
        for (int i = 0; i <= delay; i++) begin
            check({nm, "_req"},  {63'd0, l2_req}, 64'd1);
            check({nm, "_rw"},   {63'd0, l2_rw}, {63'd0, erw});
            check({nm, "_addr"}, {36'd0, l2_addr}, {36'd0, ea});
            check({nm, "_stall"}, {63'd0, stall}, 64'd1);
            check({nm, "_nostrobe"}, {62'd0, block0_rw, block1_rw}, {62'd0, RD, RD});
            if (i == delay) l2_ack = 1'b1;
            cyc();
            l2_ack = 1'b0;
        end
    endtask

    task automatic update_phase(input logic way, input logic dw, input logic [20:0] twd);
        check("upd_b0", {63'd0, block0_rw}, {63'd0, (way == 1'b0) ? WR : RD});
        check("upd_b1", {63'd0, block1_rw}, {63'd0, (way == 1'b1) ? WR : RD});
        check("upd_tag_wd", {43'd0, tag_wd}, {43'd0, twd});
        check("upd_dirty_wd", {63'd0, dirty_wd}, {63'd0, dw});
        check("upd_l2_req", {63'd0, l2_req}, 64'd0);
        cyc();
        check("upd_ready", {63'd0, ready}, 64'd1);
        check("upd_wait_nostrobe", {62'd0, block0_rw, block1_rw}, {62'd0, RD, RD});
        req = 1'b0;
        cyc();
        check("upd_idle_ready", {63'd0, ready}, 64'd0);
        check("upd_idle_stall", {63'd0, stall}, 64'd0);
    endtask

    initial begin
        cyc();
        cyc();
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_hit", {63'd0, hit}, 64'd0);
        check("rst_l2", {35'd0, l2_req, l2_rw, l2_addr}, 64'd0);
        check("rst_strobes", {62'd0, block0_rw, block1_rw}, {62'd0, RD, RD});
        check("rst_wd", {42'd0, dirty_wd, tag_wd}, 64'd0);
        check("rst_cnt", {hit_cnt, miss_cnt}, 64'd0);
        reset = 1'b1;
        cyc();

        // Cold load miss: clean refill into way 0.
        issue(RD, 32'h0000_1230);
        miss_cmp();
        l2_phase("ld_refill", RD, 28'h0000123, 0);
        update_phase(1'b0, 1'b0, 21'h100001);

        // Same load hits way 0.
        issue(RD, 32'h0000_1230);
        hit_phase(1'b0, 1'b0, 21'h100001);

        // Stores to index 0x23 forcing a dirty eviction.
        issue(WR, 32'h0000_1230);
        hit_phase(1'b0, 1'b1, 21'h100001);
        issue(WR, 32'h0000_2230);
        miss_cmp();
        l2_phase("st2_refill", RD, 28'h0000223, 0);
        update_phase(1'b1, 1'b1, 21'h100002);
        issue(WR, 32'h0000_3230);
        miss_cmp();
        l2_phase("st3_wb", WR, 28'h0000123, 0);
        l2_phase("st3_refill", RD, 28'h0000323, 20);
        update_phase(1'b0, 1'b1, 21'h100003);

`ifdef DCACHE_PERF_CNT_EN
        check("cnt_hit", {32'd0, hit_cnt}, 64'd2);
        check("cnt_miss", {32'd0, miss_cnt}, 64'd3);
`else
        check("cnt_hit_off", {32'd0, hit_cnt}, 64'd0);
        check("cnt_miss_off", {32'd0, miss_cnt}, 64'd0);
`endif

        // Stray ack in IDLE does nothing.
        l2_ack = 1'b1;
        cyc();
        l2_ack = 1'b0;
        check("stray_ack_req", {63'd0, l2_req}, 64'd0);
        check("stray_ack_stall", {63'd0, stall}, 64'd0);
        cyc();
        check("stray_ack_req2", {63'd0, l2_req}, 64'd0);

        // Reset during write-back of dirty way 1 (tag 2).
        issue(RD, 32'h0000_4230);
        miss_cmp();
        check("abort_wb_req", {63'd0, l2_req}, 64'd1);
        check("abort_wb_addr", {36'd0, l2_addr}, 64'h0000223);
        reset = 1'b0;
        req = 1'b0;
        #1;
        check("abort_async_req", {63'd0, l2_req}, 64'd0);
        check("abort_async_stall", {63'd0, stall}, 64'd0);
        cyc();
        check("abort_req", {63'd0, l2_req}, 64'd0);
        check("abort_stall", {63'd0, stall}, 64'd0);
        reset = 1'b1;
        cyc();

        // Retry misses again and completes the eviction.
        issue(RD, 32'h0000_4230);
        miss_cmp();
        l2_phase("retry_wb", WR, 28'h0000223, 0);
        l2_phase("retry_refill", RD, 28'h0000423, 0);
        update_phase(1'b1, 1'b0, 21'h100004);

`ifdef DCACHE_PERF_CNT_EN
        check("cnt_hit_post", {32'd0, hit_cnt}, 64'd0);
        check("cnt_miss_post", {32'd0, miss_cnt}, 64'd1);
`else
        check("cnt_hit_post_off", {32'd0, hit_cnt}, 64'd0);
        check("cnt_miss_post_off", {32'd0, miss_cnt}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
